// File: rtl/four_bit_adder.sv
// four_bit_adder: 4-bit unsigned ripple-carry adder with carry-in.
// Sum and carry-out are registered, so results appear one clock after the
// operands are sampled. There is no input register.

`timescale 1ns/1ps

// half_adder: single-bit add of two inputs, no carry-in.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// full_adder: two half adders plus an OR to merge their carries.
// The first half adder forms a^b and a&b. The second half adder adds cin to
// form the sum and cin&(a^b). The two carries can never both be 1, so an OR
// merges them exactly.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;
    logic g;
    logic pc;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (p),
        .c (g)
    );

    half_adder u_ha1 (
        .a (p),
        .b (cin),
        .s (s),
        .c (pc)
    );

    assign cout = g | pc;
endmodule

// four_bit_adder: four chained full adders feeding a 5-bit output register.
module four_bit_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C,
    output logic [3:0] S,
    output logic       Cy
);
    // c[i] is the carry into stage i. c[4] is the carry out of the top stage.
    logic [4:0] c;
    logic [3:0] sum_next;
    logic [3:0] s_reg;
    logic       cy_reg;

    assign c[0] = C;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stage
            full_adder u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (c[gi]),
                .s    (sum_next[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    // Output register. A reset edge discards the result that would have loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg  <= 4'b0000;
            cy_reg <= 1'b0;
        end else begin
            s_reg  <= sum_next;
            cy_reg <= c[4];
        end
    end

    assign S  = s_reg;
    assign Cy = cy_reg;
endmodule

// File: tb/tb_four_bit_adder.sv
// tb_four_bit_adder: directed and randomized checks of four_bit_adder against
// an arithmetic model {Cy,S} = A + B + C, with the result delayed one clock.

`timescale 1ns/1ps

module tb_four_bit_adder;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] s;
    logic       cy;

    int vectors    = 0;
    int miscompares = 0;

    four_bit_adder dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .B   (b),
        .C   (c),
        .S   (s),
        .Cy  (cy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer addition, or zero on a reset edge.
    function automatic logic [4:0] model(input int ai, input int bi, input int ci, input logic r);
        int total;
        total = ai + bi + ci;
        if (r) return 5'd0;
        return total[4:0];
    endfunction

    // Compare the registered outputs with an expected 5-bit {Cy,S}.
    task automatic check(input string tag, input logic [4:0] exp);
        vectors++;
        assert ({cy, s} === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed Cy=%b S=%b expected Cy=%b S=%b",
                   tag, cy, s, exp[4], exp[3:0]);
        end
    endtask

    // Drive one operand set, clock it in, then check 1 ns after the edge.
    task automatic step(input string tag, input logic r, input logic [3:0] ai,
                        input logic [3:0] bi, input logic ci);
        logic [4:0] exp;
        rst = r;
        a   = ai;
        b   = bi;
        c   = ci;
        exp = model(int'(ai), int'(bi), int'(ci), r);
        @(posedge clk);
        #1;
        $display("%s: rst=%b A=%h B=%h C=%b -> Cy=%b S=%b (exp %b %b)",
                 tag, r, ai, bi, ci, cy, s, exp[4], exp[3:0]);
        check(tag, exp);
    endtask

    initial begin
        logic [4:0]  held;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        rc;
        logic [12:0] cnt;

        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        c   = 1'b1;

        // Reset held over two edges with full-scale operands.
        step("reset0", 1'b1, 4'hF, 4'hF, 1'b1);
        step("reset1", 1'b1, 4'hF, 4'hF, 1'b1);
        step("reset_release", 1'b0, 4'hF, 4'hF, 1'b1);

        // Basic sums.
        step("zero",  1'b0, 4'b0000, 4'b0000, 1'b0);
        step("1+3",   1'b0, 4'b0001, 4'b0011, 1'b0);
        step("A+5",   1'b0, 4'b1010, 4'b0101, 1'b0);

        // Carry-out and wrap.
        step("F+F",   1'b0, 4'b1111, 4'b1111, 1'b0);
        step("F+1+1", 1'b0, 4'b1111, 4'b0001, 1'b1);
        step("B+C+1", 1'b0, 4'b1011, 4'b1100, 1'b1);

        // Carry propagates through every stage.
        step("ripple", 1'b0, 4'b1111, 4'b0000, 1'b1);

        // Operands changed between edges must not disturb the outputs.
        held = {cy, s};
        a = 4'h3;
        b = 4'h4;
        c = 1'b0;
        #3;
        check("between_edges", held);

        // Back-to-back random stream with one mid-stream reset edge.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            step((i == 20) ? "midstream_rst" : "stream", (i == 20), ra, rb, rc);
        end

        // Exhaustive sweep of all A, B, C combinations, one per cycle.
        for (int i = 0; i < 512; i++) begin
            cnt = 13'(i);
            step("exhaustive", 1'b0, cnt[8:5], cnt[4:1], cnt[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
